// File: rtl/alu_seg_if.sv
// Bus between the 4-bit ALU side and the 7-segment result display.
// res_valid is a capture strobe with no back-pressure: while it is high, the display takes one result per cycle.
interface alu_seg_if #(
  parameter int HIST_DEPTH = 4
);
  localparam int SEL_W = $clog2(HIST_DEPTH);

  logic             res_valid;
  logic [3:0]       res;
  logic             car;
  logic             of;
  logic             clr;
  logic             signed_mode;
  logic [SEL_W-1:0] hist_sel;
  logic [7:0]       seg0;
  logic [7:0]       seg1;
  logic [7:0]       seg2;
  logic [7:0]       seg3;

  modport master (
    output res_valid, res, car, of, clr, signed_mode, hist_sel,
    input  seg0, seg1, seg2, seg3
  );

  modport slave (
    input  res_valid, res, car, of, clr, signed_mode, hist_sel,
    output seg0, seg1, seg2, seg3
  );
endinterface

// File: rtl/alu_seg_display.sv
// Captures ALU results into a short history and shows the selected entry on four active-low 7-seg digits.
// Optional feature macro: ALU_SEG_BLINK_EN (blinks the overflow glyph at BLINK_DIV cycles per half-period).
module alu_seg_display #(
  parameter int HIST_DEPTH = 4,
  parameter int BLINK_DIV  = 25_000_000
) (
  input logic      clk,
  input logic      rst,
  alu_seg_if.slave bus
);
  localparam int SEL_W = $clog2(HIST_DEPTH);
  localparam logic [7:0] BLANK   = 8'hFF;
  localparam logic [7:0] G_MINUS = 8'hFD;
  localparam logic [7:0] G_CARRY = 8'h63;
  localparam logic [7:0] G_OVF   = 8'hC5;

  typedef struct packed {
    logic [3:0] res;
    logic       car;
    logic       of;
  } entry_t;

  entry_t         hist [HIST_DEPTH];
  logic [SEL_W:0] count;

  // History shifts only on capture; clr just hides old entries by zeroing count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      if (bus.res_valid) begin
        for (int i = HIST_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= '{res: bus.res, car: bus.car, of: bus.of};
      end
      if (bus.clr) begin
        count <= bus.res_valid ? (SEL_W+1)'(1) : '0;
      end else if (bus.res_valid && count != (SEL_W+1)'(HIST_DEPTH)) begin
        count <= count + (SEL_W+1)'(1);
      end
    end
  end

  logic blink_on;
`ifdef ALU_SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blink_on = blink_phase;
`else
  assign blink_on = 1'b1;
`endif

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'h03;
      4'h1: glyph = 8'h9F;
      4'h2: glyph = 8'h25;
      4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h49;
      4'h6: glyph = 8'h41;
      4'h7: glyph = 8'h1F;
      4'h8: glyph = 8'h01;
      4'h9: glyph = 8'h09;
      4'hA: glyph = 8'h11;
      4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;
      4'hD: glyph = 8'h85;
      4'hE: glyph = 8'h61;
      default: glyph = 8'h71;
    endcase
  endfunction

  entry_t     sel_entry;
  logic       sel_ok;
  logic       neg;
  logic [3:0] mag;
  logic [7:0] seg0_d, seg1_d, seg2_d, seg3_d;

  // Magnitude of -8 wraps back to 4'b1000, which is exactly the '8' glyph needed.
  always_comb begin
    sel_entry = hist[bus.hist_sel];
    sel_ok    = {1'b0, bus.hist_sel} < count;
    neg       = bus.signed_mode & sel_entry.res[3];
    mag       = neg ? (~sel_entry.res + 4'd1) : sel_entry.res;
    seg0_d    = BLANK;
    seg1_d    = BLANK;
    seg2_d    = BLANK;
    seg3_d    = BLANK;
    if (sel_ok) begin
      seg0_d = glyph(mag);
      seg1_d = neg ? G_MINUS : BLANK;
      seg2_d = sel_entry.car ? G_CARRY : BLANK;
      seg3_d = (sel_entry.of && blink_on) ? G_OVF : BLANK;
    end
  end

  logic [7:0] seg0_q, seg1_q, seg2_q, seg3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg0_q <= BLANK;
      seg1_q <= BLANK;
      seg2_q <= BLANK;
      seg3_q <= BLANK;
    end else begin
      seg0_q <= seg0_d;
      seg1_q <= seg1_d;
      seg2_q <= seg2_d;
      seg3_q <= seg3_d;
    end
  end

  assign bus.seg0 = seg0_q;
  assign bus.seg1 = seg1_q;
  assign bus.seg2 = seg2_q;
  assign bus.seg3 = seg3_q;
endmodule

// File: tb/tb_alu_seg_display.sv
// Directed bench for alu_seg_display: a queue-based history model checked every cycle, plus literal spot checks.
module tb_alu_seg_display;
  localparam int HD = 4;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seg_if #(.HIST_DEPTH(HD)) bus ();

  alu_seg_display #(.HIST_DEPTH(HD), .BLINK_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] gly(input int d);
    case (d)
      0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
      4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
      8: return 8'h01;  9: return 8'h09;  10: return 8'h11; 11: return 8'hC1;
      12: return 8'h63; 13: return 8'h85; 14: return 8'h61; default: return 8'h71;
    endcase
  endfunction

  // Model: history as a queue of {res,car,of}, newest at the front.
  logic [5:0] hist_q[$];
  logic [5:0] ent;
  logic [3:0] r;
  logic [7:0] e0, e1, e2, e3;
  logic       model_on = 1'b0;
  logic       phase;
  int         ncyc, sel, v;

  always @(posedge clk) begin
    if (rst) begin
      hist_q.delete();
      ncyc = 0;
      {e0, e1, e2, e3} = {4{8'hFF}};
      model_on = 1'b1;
    end else begin
      sel = int'(bus.hist_sel);
`ifdef ALU_SEG_BLINK_EN
      phase = ((ncyc / BD) % 2) == 0;
`else
      phase = 1'b1;
`endif
      if (sel >= hist_q.size()) begin
        {e0, e1, e2, e3} = {4{8'hFF}};
      end else begin
        ent = hist_q[sel];
        r   = ent[5:2];
        v   = bus.signed_mode ? int'($signed(r)) : int'(r);
        e0  = gly(v < 0 ? -v : v);
        e1  = (v < 0) ? 8'hFD : 8'hFF;
        e2  = ent[1] ? 8'h63 : 8'hFF;
        e3  = (ent[0] && phase) ? 8'hC5 : 8'hFF;
      end
      ncyc++;
      if (bus.clr) hist_q.delete();
      if (bus.res_valid) hist_q.push_front({bus.res, bus.car, bus.of});
      if (hist_q.size() > HD) void'(hist_q.pop_back());
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      cmp("model_seg0", bus.seg0, e0);
      cmp("model_seg1", bus.seg1, e1);
      cmp("model_seg2", bus.seg2, e2);
      cmp("model_seg3", bus.seg3, e3);
    end
  end

  task automatic expect_segs(input string name, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    cmp({name, "_seg0"}, bus.seg0, s0);
    cmp({name, "_seg1"}, bus.seg1, s1);
    cmp({name, "_seg2"}, bus.seg2, s2);
    cmp({name, "_seg3"}, bus.seg3, s3);
  endtask

  task automatic push(input logic [3:0] rv, input logic cv, input logic ov);
    @(negedge clk);
    bus.res_valid = 1'b1;
    bus.res = rv;
    bus.car = cv;
    bus.of  = ov;
    @(negedge clk);
    bus.res_valid = 1'b0;
  endtask

  task automatic set_sel(input int s);
    bus.hist_sel = 2'(s);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.res_valid = 1'b1;
    bus.res = 4'd5;
    bus.car = 1'b1;
    bus.of = 1'b1;
    bus.clr = 1'b0;
    bus.signed_mode = 1'b0;
    bus.hist_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.res_valid = 1'b0;
    @(negedge clk);
    expect_segs("reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    bus.signed_mode = 1'b1;
    push(4'b1101, 1'b1, 1'b0);
    @(negedge clk);
    expect_segs("neg3_carry", 8'h0D, 8'hFD, 8'h63, 8'hFF);

    bus.signed_mode = 1'b0;
    push(4'hF, 1'b0, 1'b0);
    @(negedge clk);
    expect_segs("hex_F", 8'h71, 8'hFF, 8'hFF, 8'hFF);

    bus.signed_mode = 1'b1;
    push(4'b1000, 1'b0, 1'b0);
    @(negedge clk);
    expect_segs("neg8", 8'h01, 8'hFD, 8'hFF, 8'hFF);
    set_sel(1);
    expect_segs("sel1_neg1", 8'h9F, 8'hFD, 8'hFF, 8'hFF);
    set_sel(0);

    bus.signed_mode = 1'b0;
    push(4'hB, 1'b1, 1'b0);
    @(negedge clk);
    expect_segs("hex_b", 8'hC1, 8'hFF, 8'h63, 8'hFF);

    bus.signed_mode = 1'b1;
    for (int i = 1; i <= 5; i++) push(4'(i), 1'b0, 1'b0);
    @(negedge clk);
    expect_segs("depth_sel0", 8'h49, 8'hFF, 8'hFF, 8'hFF);
    set_sel(3);
    expect_segs("depth_sel3", 8'h25, 8'hFF, 8'hFF, 8'hFF);
    set_sel(1);
    expect_segs("depth_sel1", 8'h99, 8'hFF, 8'hFF, 8'hFF);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    @(negedge clk);
    expect_segs("clr_sel1", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_sel(0);
    expect_segs("clr_sel0", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    push(4'd0, 1'b0, 1'b1);
    @(negedge clk);
`ifndef ALU_SEG_BLINK_EN
    for (int i = 0; i < 8; i++) begin
      expect_segs("ovf_steady", 8'h03, 8'hFF, 8'hFF, 8'hC5);
      @(negedge clk);
    end
`else
    repeat (12) @(negedge clk);
`endif

    push(4'd3, 1'b0, 1'b0);
    @(negedge clk);
    bus.clr = 1'b1;
    bus.res_valid = 1'b1;
    bus.res = 4'd7;
    bus.car = 1'b0;
    bus.of = 1'b0;
    @(negedge clk);
    bus.clr = 1'b0;
    bus.res_valid = 1'b0;
    @(negedge clk);
    expect_segs("clr_push_sel0", 8'h1F, 8'hFF, 8'hFF, 8'hFF);
    set_sel(1);
    expect_segs("clr_push_sel1", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_sel(0);

    rst = 1'b1;
    bus.res_valid = 1'b1;
    bus.clr = 1'b1;
    bus.res = 4'd2;
    @(negedge clk);
    rst = 1'b0;
    bus.res_valid = 1'b0;
    bus.clr = 1'b0;
    @(negedge clk);
    expect_segs("rst_override", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
